// File: rtl/mpu_load_if.sv
// Load-path bundle between the load transaction driver (master) and the load unit (slave),
// including the register-file write port the unit drives.
interface mpu_load_if #(
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int MATRIX_REG_BITS = 3,
  parameter int FW              = 32
);
  localparam int MBITS = $clog2(M);
  localparam int NBITS = $clog2(N);

  logic                     load_req;
  logic [MBITS:0]           mem_m_load_size;
  logic [NBITS:0]           mem_n_load_size;
  logic [MATRIX_REG_BITS:0] mem_load_addr;
  logic [FW-1:0]            mem_load_element;
  logic                     mem_load_ack;
  logic                     mem_load_error;
  logic                     load_ready;

  logic                     reg_load_req;
  logic [MATRIX_REG_BITS:0] reg_load_addr;
  logic [FW-1:0]            reg_load_element;
  logic [MBITS:0]           reg_m_load_size;
  logic [NBITS:0]           reg_n_load_size;
  logic [MBITS:0]           reg_i_load_loc;
  logic [NBITS:0]           reg_j_load_loc;

  // Handshake: the master raises load_req and holds it until it sees mem_load_ack fall; each
  // ack-high cycle entitles the master to present one element in the following cycle.
  modport master (
    output load_req, mem_m_load_size, mem_n_load_size, mem_load_addr, mem_load_element,
    input  mem_load_ack, mem_load_error, load_ready,
    input  reg_load_req, reg_load_addr, reg_load_element, reg_m_load_size, reg_n_load_size,
    input  reg_i_load_loc, reg_j_load_loc
  );

  modport slave (
    input  load_req, mem_m_load_size, mem_n_load_size, mem_load_addr, mem_load_element,
    output mem_load_ack, mem_load_error, load_ready,
    output reg_load_req, reg_load_addr, reg_load_element, reg_m_load_size, reg_n_load_size,
    output reg_i_load_loc, reg_j_load_loc
  );
endinterface

// File: rtl/mpu_load_unit.sv
// Matrix load engine: validates dimensions, opens an m*n-cycle ack window, and turns each
// element arriving one cycle behind the ack into a register-file write with its (i, j) location.
module mpu_load_unit #(
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int MBITS           = $clog2(M),
  parameter int NBITS           = $clog2(N),
  parameter int MATRIX_REG_BITS = 3,
  parameter int FW              = 32
) (
  input  logic       clk,
  input  logic       rst,
  mpu_load_if.slave  bus,
  output logic [2:0] dbg_state
);
  localparam int CW = $clog2(M * N + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACK   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [MBITS:0] M_MAX = M[MBITS:0];
  localparam logic [NBITS:0] N_MAX = N[NBITS:0];

  logic [2:0]               state;
  logic [CW-1:0]            cnt;
  logic                     ack;
  logic                     ack_d;
  logic [MBITS:0]           i_cnt, m_q, i_loc;
  logic [NBITS:0]           j_cnt, n_q, j_loc;
  logic [MATRIX_REG_BITS:0] addr_q;
  logic [FW-1:0]            elem_q;
  logic                     req_q;
  logic                     size_ok;
  logic [CW-1:0]            prod;

  assign size_ok = (bus.mem_m_load_size != '0) && (bus.mem_m_load_size <= M_MAX) &&
                   (bus.mem_n_load_size != '0) && (bus.mem_n_load_size <= N_MAX);
  assign prod    = CW'(bus.mem_m_load_size) * CW'(bus.mem_n_load_size);

  assign ack                  = (state == S_ACK);
  assign bus.mem_load_ack     = ack;
  assign bus.mem_load_error   = (state == S_ERR);
  assign bus.load_ready       = (state == S_IDLE);
  assign bus.reg_load_req     = req_q;
  assign bus.reg_load_addr    = addr_q;
  assign bus.reg_load_element = elem_q;
  assign bus.reg_m_load_size  = m_q;
  assign bus.reg_n_load_size  = n_q;
  assign bus.reg_i_load_loc   = i_loc;
  assign bus.reg_j_load_loc   = j_loc;
  assign dbg_state            = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      ack_d  <= 1'b0;
      i_cnt  <= '0;
      j_cnt  <= '0;
      m_q    <= '0;
      n_q    <= '0;
      addr_q <= '0;
      req_q  <= 1'b0;
      elem_q <= '0;
      i_loc  <= '0;
      j_loc  <= '0;
    end else begin
      ack_d <= ack;
      req_q <= ack_d;
      // The element for an ack cycle arrives one cycle later; the location advances with the write.
      if (ack_d) begin
        elem_q <= bus.mem_load_element;
        i_loc  <= i_cnt;
        j_loc  <= j_cnt;
        if (j_cnt == n_q - 1'b1) begin
          j_cnt <= '0;
          i_cnt <= i_cnt + 1'b1;
        end else begin
          j_cnt <= j_cnt + 1'b1;
        end
      end
      case (state)
        S_IDLE: begin
          if (bus.load_req) begin
            if (size_ok) begin
              m_q    <= bus.mem_m_load_size;
              n_q    <= bus.mem_n_load_size;
              addr_q <= bus.mem_load_addr;
              cnt    <= prod;
              i_cnt  <= '0;
              j_cnt  <= '0;
              state  <= S_ACK;
            end else begin
              state <= S_ERR;
            end
          end
        end
        S_ACK: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_DRAIN;
        end
        S_DRAIN: state <= S_HOLD;
        // A request still held high after a load or an error must not retrigger.
        S_HOLD, S_ERR: begin
          if (!bus.load_req) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mpu_load_unit.sv
// Directed bench for mpu_load_unit: a vector table of loads plus hand-written back-to-back
// and reset-abort sequences, with a producer model and a write scoreboard.
module tb_mpu_load_unit;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACK  = 3'd1;
  localparam logic [2:0] S_ERR  = 3'd4;
  localparam int NV = 8;

  typedef struct {
    logic [2:0]  m;
    logic [2:0]  n;
    logic [3:0]  addr;
    logic [31:0] seed;
    bit          is_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  mpu_load_if bus ();

  mpu_load_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  logic [37:0] exp_q[$];
  logic [31:0] src_q[$];
  logic [31:0] float_tab [6];

  int   e0 = 0;
  int   ack_cnt, first_ack, last_ack, str_cnt, first_str, last_str, err_cnt, rdy_low;
  logic ack_last = 1'b0;
  logic [2:0] last_m = '0, last_n = '0;
  logic [3:0] last_addr = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // monitor + scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    int          rel;
    logic [37:0] e;
    rel      = cyc - e0 + 1;
    ack_last = bus.mem_load_ack;
    if (bus.mem_load_ack) begin
      ack_cnt++;
      if (first_ack < 0) first_ack = rel;
      last_ack = rel;
    end
    if (bus.reg_load_req) begin
      str_cnt++;
      if (first_str < 0) first_str = rel;
      last_str = rel;
      check("strobe_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("strobe_data", {26'd0, bus.reg_i_load_loc, bus.reg_j_load_loc, bus.reg_load_element},
              {26'd0, e});
      end
    end
    if (bus.mem_load_error) err_cnt++;
    if (!bus.load_ready) rdy_low++;
  end

  // producer: element k appears in the cycle after the k-th ack-high cycle, junk otherwise
  always @(posedge clk) begin
    #1;
    if (ack_last && src_q.size() > 0) bus.mem_load_element = src_q.pop_front();
    else bus.mem_load_element = $urandom;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_load(input logic [2:0] m, input logic [2:0] n, input logic [3:0] addr,
                            input logic [31:0] seed, input bit is_err);
    ack_cnt = 0; first_ack = -1; last_ack = -1;
    str_cnt = 0; first_str = -1; last_str = -1;
    err_cnt = 0; rdy_low = 0;
    e0 = cyc + 1;
    if (!is_err) begin
      for (int k = 0; k < int'(m) * int'(n); k++) begin
        logic [31:0] v;
        v = (seed == 32'd0) ? float_tab[k] : seed + 32'(k);
        src_q.push_back(v);
        exp_q.push_back({3'(k / int'(n)), 3'(k % int'(n)), v});
      end
    end
    bus.load_req        = 1'b1;
    bus.mem_m_load_size = m;
    bus.mem_n_load_size = n;
    bus.mem_load_addr   = addr;
    step();
    e0 = cyc;
    check("accept_state", dbg_state, is_err ? S_ERR : S_ACK);
    check("ready_low_after_accept", bus.load_ready, 0);
    if (!is_err) begin
      last_m = m; last_n = n; last_addr = addr;
    end
  endtask

  task automatic finish_load(input int extra);
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while (bus.mem_load_ack && guard < 40);
    check("ack_falls", bus.mem_load_ack, 0);
    repeat (extra) step();
    bus.load_req = 1'b0;
  endtask

  task automatic wait_ready();
    for (int g = 0; g < 40 && !bus.load_ready; g++) step();
    check("ready_returns", bus.load_ready, 1);
  endtask

  task automatic check_ok(input logic [2:0] m, input logic [2:0] n, input logic [3:0] addr,
                          input int rdy_exp);
    int mn;
    mn = int'(m) * int'(n);
    check("ack_count", ack_cnt, mn);
    check("ack_first_cycle", first_ack, 1);
    check("ack_last_cycle", last_ack, mn);
    check("strobe_count", str_cnt, mn);
    check("strobe_first_cycle", first_str, 3);
    check("strobe_last_cycle", last_str, mn + 2);
    check("writes_outstanding", exp_q.size(), 0);
    check("ready_low_cycles", rdy_low, rdy_exp);
    check("no_error", err_cnt, 0);
    check("reg_m", bus.reg_m_load_size, m);
    check("reg_n", bus.reg_n_load_size, n);
    check("reg_addr", bus.reg_load_addr, addr);
  endtask

  task automatic check_err();
    check("err_cycles", err_cnt, 3);
    check("err_no_ack", ack_cnt, 0);
    check("err_no_strobe", str_cnt, 0);
    check("err_ready_low", rdy_low, 3);
    check("err_holds_m", bus.reg_m_load_size, last_m);
    check("err_holds_n", bus.reg_n_load_size, last_n);
    check("err_holds_addr", bus.reg_load_addr, last_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [NV];
    int   e_first;

    float_tab[0] = 32'h3F80_0000; float_tab[1] = 32'h4000_0000; float_tab[2] = 32'h4040_0000;
    float_tab[3] = 32'h4080_0000; float_tab[4] = 32'h40A0_0000; float_tab[5] = 32'h40C0_0000;

    vecs[0] = '{m: 3'd2, n: 3'd3, addr: 4'd2,  seed: 32'h0000_0000, is_err: 1'b0};
    vecs[1] = '{m: 3'd1, n: 3'd1, addr: 4'd5,  seed: 32'h4049_0FDB, is_err: 1'b0};
    vecs[2] = '{m: 3'd4, n: 3'd4, addr: 4'd7,  seed: 32'hA000_0000, is_err: 1'b0};
    vecs[3] = '{m: 3'd0, n: 3'd2, addr: 4'd3,  seed: 32'h1111_0000, is_err: 1'b1};
    vecs[4] = '{m: 3'd5, n: 3'd2, addr: 4'd4,  seed: 32'h2222_0000, is_err: 1'b1};
    vecs[5] = '{m: 3'd3, n: 3'd0, addr: 4'd9,  seed: 32'h3333_0000, is_err: 1'b1};
    vecs[6] = '{m: 3'd4, n: 3'd1, addr: 4'd9,  seed: 32'h1234_0000, is_err: 1'b0};
    vecs[7] = '{m: 3'd1, n: 3'd4, addr: 4'd15, seed: 32'hC0DE_0000, is_err: 1'b0};

    rst                 = 1'b0;
    bus.load_req        = 1'b0;
    bus.mem_m_load_size = '0;
    bus.mem_n_load_size = '0;
    bus.mem_load_addr   = '0;
    ack_cnt = 0; first_ack = -1; last_ack = -1; str_cnt = 0; first_str = -1; last_str = -1;
    err_cnt = 0; rdy_low = 0;
    repeat (3) step();

    check("rst_ready", bus.load_ready, 1);
    check("rst_ack", bus.mem_load_ack, 0);
    check("rst_error", bus.mem_load_error, 0);
    check("rst_req", bus.reg_load_req, 0);
    check("rst_addr", bus.reg_load_addr, 0);
    check("rst_m", bus.reg_m_load_size, 0);
    check("rst_n", bus.reg_n_load_size, 0);
    check("rst_i", bus.reg_i_load_loc, 0);
    check("rst_j", bus.reg_j_load_loc, 0);
    check("rst_elem", bus.reg_load_element, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst = 1'b1;
    step();

    for (int v = 0; v < NV; v++) begin
      start_load(vecs[v].m, vecs[v].n, vecs[v].addr, vecs[v].seed, vecs[v].is_err);
      finish_load(vecs[v].is_err ? 1 : 0);
      wait_ready();
      step();
      step();
      if (vecs[v].is_err) check_err();
      else check_ok(vecs[v].m, vecs[v].n, vecs[v].addr, int'(vecs[v].m) * int'(vecs[v].n) + 2);
    end

    // back-to-back 3x3: request held into HOLD, low for one cycle, then raised again
    start_load(3'd3, 3'd3, 4'd6, 32'h3000_0000, 1'b0);
    e_first = e0;
    finish_load(2);
    step();
    check("b2b_idle_between", dbg_state, S_IDLE);
    check_ok(3'd3, 3'd3, 4'd6, 12);
    start_load(3'd3, 3'd3, 4'd1, 32'h3100_0000, 1'b0);
    check("b2b_accept_gap", e0 - e_first, 13);
    finish_load(0);
    wait_ready();
    step();
    step();
    check_ok(3'd3, 3'd3, 4'd1, 11);

    // reset after the 4th strobe of a 3x3 load
    start_load(3'd3, 3'd3, 4'd8, 32'h5000_0000, 1'b0);
    for (int g = 0; g < 40 && str_cnt < 4; g++) step();
    rst          = 1'b0;
    bus.load_req = 1'b0;
    #1;
    check("abort_ready", bus.load_ready, 1);
    check("abort_ack", bus.mem_load_ack, 0);
    check("abort_error", bus.mem_load_error, 0);
    check("abort_req", bus.reg_load_req, 0);
    check("abort_addr", bus.reg_load_addr, 0);
    check("abort_m", bus.reg_m_load_size, 0);
    check("abort_n", bus.reg_n_load_size, 0);
    check("abort_i", bus.reg_i_load_loc, 0);
    check("abort_j", bus.reg_j_load_loc, 0);
    check("abort_elem", bus.reg_load_element, 0);
    check("abort_state", dbg_state, S_IDLE);
    check("abort_strobes_before", str_cnt, 4);
    exp_q.delete();
    src_q.delete();
    step();
    step();
    rst = 1'b1;
    repeat (5) step();
    check("abort_no_more_strobes", str_cnt, 4);

    start_load(3'd2, 3'd2, 4'd3, 32'h6000_0000, 1'b0);
    finish_load(0);
    wait_ready();
    step();
    step();
    check_ok(3'd2, 3'd2, 4'd3, 6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mpu_load_unit.md
# mpu_load_unit

Memory-side load engine of the matrix processor, directly downstream of the load transaction driver. Accepts a load request with matrix dimensions and a destination register address, streams the row-major float elements in under an acknowledge handshake, and issues one register-file write per element with its (i, j) location. Illegal dimensions are rejected with an error flag and no register writes.

## Interface
- M, 4: maximum matrix rows
- N, 4: maximum matrix columns
- MBITS, $clog2(M): row index/size MSB index; fields are MBITS+1 bits wide
- NBITS, $clog2(N): column index/size MSB index; fields are NBITS+1 bits wide
- MATRIX_REG_BITS, 3: register address MSB index; address fields are MATRIX_REG_BITS+1 bits wide
- FW, 32: float_sp element width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- load_req  in  1  load request; held high by producer until mem_load_ack falls
- mem_m_load_size  in  MBITS+1  row count m
- mem_n_load_size  in  NBITS+1  column count n
- mem_load_addr  in  MATRIX_REG_BITS+1  destination matrix register
- mem_load_element  in  FW  incoming element, row-major
- mem_load_ack  out  1  element acceptance window
- mem_load_error  out  1  dimension error flag
- load_ready  out  1  high only in IDLE
- reg_load_req  out  1  register-file write strobe, one cycle per element
- reg_load_addr  out  MATRIX_REG_BITS+1  latched destination
- reg_load_element  out  FW  element to write
- reg_m_load_size / reg_n_load_size  out  MBITS+1 / NBITS+1  latched m, n
- reg_i_load_loc / reg_j_load_loc  out  MBITS+1 / NBITS+1  element location

## Operation
- States: IDLE, ACK, DRAIN, HOLD, ERR.
- IDLE: load_ready=1. On an edge with load_req=1: if 1<=m<=M and 1<=n<=N, latch m, n, addr; load counter with m*n; clear i, j; go ACK. Otherwise go ERR.
- ACK: mem_load_ack=1; counter decrements each cycle; after exactly m*n ack-high cycles go DRAIN (ack low).
- Producer protocol: element k is presented in the cycle after the k-th ack-high cycle. Unit keeps ack_d = mem_load_ack delayed one cycle; on every edge with ack_d=1 it captures mem_load_element and registers a write: reg_load_req=1, reg_load_element=captured value, location=(i, j); then j+1, wrapping to 0 with i+1 when j=n-1.
- DRAIN: one cycle; performs the final capture; go HOLD.
- HOLD: wait for load_req=0, then IDLE. Prevents re-triggering on a request still held high.
- ERR: mem_load_error=1, ack never asserted, no register writes; leave to IDLE when load_req=0.
- reg_load_addr, reg_m_load_size and reg_n_load_size hold latched values from acceptance until the next acceptance.
- Inputs are ignored outside IDLE and ack_d windows; mem_load_element is not sampled otherwise.

## Timing
- Reset (rst=0, asynchronous): state IDLE; load_ready=1; all other outputs 0; counters 0.
- Acceptance edge E0 -> mem_load_ack high during cycles 1..m*n after E0.
- reg_load_req high during cycles 3..m*n+2 after E0, contiguous, exactly m*n pulses.
- Last write location = (m-1, n-1); the wrap from j=n-1 to (i+1, 0) takes effect on the same edge as the write.
- load_ready low from E0 until the edge after load_req is seen low in HOLD/ERR.
- Error: mem_load_error high from the cycle after the request edge until the edge after load_req falls.
- Reset mid-transfer: immediate abort; partial writes stay in the register file; no further strobes are issued.

## Test plan
- 2x3 load to addr 2, elements 1.0..6.0 -> ack 6 cycles; 6 strobes with locations (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) and matching values; m=2, n=3, addr=2 held on outputs.
- 1x1 load of 0x40490FDB -> ack 1 cycle; single strobe at (0,0) in cycle 3 after acceptance.
- 4x4 full-size load -> 16 ack cycles, 16 contiguous strobes, last at (3,3); counter reaches 0 without underflow.
- m=0, then m=5 (n=2) -> mem_load_error high, ack and reg_load_req stay 0; returns to IDLE once load_req drops.
- Two 3x3 loads back-to-back, load_req dropping for one cycle between -> second load is accepted only after HOLD exits; no strobe overlap between loads.
- rst low after the 4th strobe of a 3x3 load -> all outputs 0 at once and load_ready=1; a following 2x2 load completes normally.
